// File: rtl/pool2x2_writeback_if.sv
// Pixel-in / pooled-word-out bundle between the output stage, the pooling
// block and the writeback consumer.
interface pool2x2_writeback_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic                     start;
  logic                     in_valid;
  logic [col*psum_bw-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [col*psum_bw-1:0]   out_data;
  logic                     frame_done;
  logic                     overflow;

  modport master (
    output start, in_valid, in_data, out_ready,
    input  out_valid, out_data, frame_done, overflow
  );

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output out_valid, out_data, frame_done, overflow
  );
endinterface

// File: rtl/pool2x2_writeback.sv
// 2x2 stride-2 signed max pooling over a raster pixel stream, one lane per
// channel, feeding a small valid/ready output FIFO.
module pool2x2_writeback #(
  parameter int col        = 8,
  parameter int psum_bw    = 16,
  parameter int fmap_w     = 4,
  parameter int fmap_h     = 4,
  parameter int fifo_depth = 4
) (
  input  logic               clk,
  input  logic               reset,
  pool2x2_writeback_if.slave bus
);
  localparam int W  = col * psum_bw;
  localparam int XW = (fmap_w > 1) ? $clog2(fmap_w) : 1;
  localparam int YW = (fmap_h > 1) ? $clog2(fmap_h) : 1;
  localparam int LW = (fmap_w / 2 > 1) ? $clog2(fmap_w / 2) : 1;
  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int CW = PW + 1;

  // Per-lane signed maximum; on a tie the first operand wins.
  function automatic logic [W-1:0] lane_max(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0]              res;
    logic signed [psum_bw-1:0] la;
    logic signed [psum_bw-1:0] lb;
    res = '0;
    for (int k = 0; k < col; k++) begin
      la = a[k*psum_bw +: psum_bw];
      lb = b[k*psum_bw +: psum_bw];
      res[k*psum_bw +: psum_bw] = (lb > la) ? lb : la;
    end
    return res;
  endfunction

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [W-1:0]  r_hreg;
  logic [W-1:0]  r_lbuf [0:(1<<LW)-1];
  logic [W-1:0]  r_mem  [0:(1<<PW)-1];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_frame_done;
  logic          r_overflow;

  logic          w_acc;
  logic          w_xlast;
  logic          w_ylast;
  logic [LW-1:0] w_lidx;
  logic [W-1:0]  w_h;
  logic [W-1:0]  w_pool;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;

  // A pixel is only consumed when no clear (reset/start) is pending this cycle.
  assign w_acc   = bus.in_valid & ~bus.start & ~reset;
  assign w_xlast = (r_x == XW'(fmap_w - 1));
  assign w_ylast = (r_y == YW'(fmap_h - 1));
  assign w_lidx  = LW'(r_x >> 1);
  assign w_h     = lane_max(r_hreg, bus.in_data);
  assign w_pool  = lane_max(r_lbuf[w_lidx], w_h);
  assign w_push  = w_acc & r_x[0] & r_y[0];
  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid & bus.out_ready;
  assign w_full  = (r_cnt == CW'(fifo_depth));
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign w_wr    = w_push & (~w_full | w_pop);

  // Control state: raster counters, pair register, FIFO pointers and flags.
  always_ff @(posedge clk) begin
    if (reset || bus.start) begin
      r_x          <= '0;
      r_y          <= '0;
      r_hreg       <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_frame_done <= w_acc & w_xlast & w_ylast;
      if (w_acc) begin
        if (!r_x[0]) r_hreg <= bus.in_data;
        if (w_xlast) begin
          r_x <= '0;
          r_y <= w_ylast ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Data storage: even-row horizontal maxima and FIFO entries, no reset needed.
  always_ff @(posedge clk) begin
    if (w_acc && r_x[0] && !r_y[0]) r_lbuf[w_lidx] <= w_h;
    if (w_wr) r_mem[r_wptr] <= w_pool;
  end

  // Head word is forced to zero while the FIFO is empty, so reset clears it.
  assign bus.out_valid  = w_valid;
  assign bus.out_data   = w_valid ? r_mem[r_rptr] : '0;
  assign bus.frame_done = r_frame_done;
  assign bus.overflow   = r_overflow;
endmodule
